imem_dmem_arbiter: RTL

- Shares one single-port unified memory between the IF-stage instruction fetch and the MEM-stage load/store port of the RV32I five-stage pipeline.
- Arbitrates between the two requesters and sequences one outstanding memory transaction at a time.
- Returns data and a completion pulse to the requester that was granted.
- Drives per-port stall signals so the pipeline freezes the affected stages while its request is pending.

---
 rtl/imem_dmem_arbiter_pkg.sv | 19 +
 rtl/arb_fair_pick.sv | 55 +++++
 rtl/imem_dmem_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter.
// Contents: controller state encoding, transaction owner encoding and the default data width.
package imem_dmem_arbiter_pkg;

  localparam int unsigned DefaultXlen = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OwnI = 1'b0,
    OwnD = 1'b1
  } owner_e;

endpackage

// File: rtl/arb_fair_pick.sv
// Fetch/data priority pick with starvation guard.
// Data normally wins a tie; after MaxDStreak consecutive data grants made while a fetch
// was waiting, the fetch wins the next tie.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   arb_en_i       arbiter is idle and may grant this cycle
//   i_req_i        fetch request
//   d_req_i        data request
//   grant_o        a grant is made this cycle
//   owner_o        which requester is granted (valid with grant_o)
module arb_fair_pick import imem_dmem_arbiter_pkg::*; #(
  parameter int unsigned MaxDStreak = 4
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   arb_en_i,
  input  logic   i_req_i,
  input  logic   d_req_i,
  output logic   grant_o,
  output owner_e owner_o
);

  localparam int unsigned StreakW = $clog2(MaxDStreak + 1);

  logic [StreakW-1:0] streak_q, streak_d;
  logic               streak_full;

  assign streak_full = (streak_q == StreakW'(MaxDStreak));

  always_comb begin
    grant_o  = arb_en_i & (i_req_i | d_req_i);
    owner_o  = OwnI;
    streak_d = streak_q;
    if (d_req_i && !(i_req_i && streak_full)) begin
      owner_o = OwnD;
    end
    if (grant_o) begin
      if (owner_o == OwnI) begin
        streak_d = '0;
      end else if (i_req_i && !streak_full) begin
        // Only data wins that actually kept a fetch waiting count towards the streak.
        streak_d = streak_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port memory between instruction fetch and the load/store port.
// One transaction at a time: IDLE (arbitrate) -> ISSUE (MEM_REQ strobe) -> WAIT (until
// MEM_RVALID or timeout) -> RESP (ACK pulse to the owner).
// Ports:
//   CLK, RST                          clock, asynchronous active-high reset
//   I_REQ/I_ADDR -> I_ACK/I_RDATA     fetch port, I_STALL while pending
//   D_REQ/D_WE/D_ADDR/D_WDATA/D_BE    data port, D_ACK/D_RDATA, D_STALL while pending
//   MEM_REQ/WE/ADDR/WDATA/BE          registered memory command
//   MEM_RDATA/MEM_RVALID              memory completion
//   ERR                               sticky timeout flag
module imem_dmem_arbiter import imem_dmem_arbiter_pkg::*; #(
  parameter int unsigned XLEN         = DefaultXlen,
  parameter int unsigned TIMEOUT      = 64,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            I_REQ,
  input  logic [XLEN-1:0] I_ADDR,
  output logic            I_ACK,
  output logic [XLEN-1:0] I_RDATA,
  output logic            I_STALL,
  input  logic            D_REQ,
  input  logic            D_WE,
  input  logic [XLEN-1:0] D_ADDR,
  input  logic [XLEN-1:0] D_WDATA,
  input  logic [3:0]      D_BE,
  output logic            D_ACK,
  output logic [XLEN-1:0] D_RDATA,
  output logic            D_STALL,
  output logic            MEM_REQ,
  output logic            MEM_WE,
  output logic [XLEN-1:0] MEM_ADDR,
  output logic [XLEN-1:0] MEM_WDATA,
  output logic [3:0]      MEM_BE,
  input  logic [XLEN-1:0] MEM_RDATA,
  input  logic            MEM_RVALID,
  output logic            ERR
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  arb_state_e      state_q, state_d;
  owner_e          owner_q, owner_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]      mem_be_q, mem_be_d;
  logic            i_ack_q, i_ack_d;
  logic            d_ack_q, d_ack_d;
  logic [XLEN-1:0] i_rdata_q, i_rdata_d;
  logic [XLEN-1:0] d_rdata_q, d_rdata_d;
  logic            err_q, err_d;
  logic [TmoW-1:0] tmo_q, tmo_d;

  logic   grant;
  owner_e pick_owner;

  arb_fair_pick #(
    .MaxDStreak (MAX_D_STREAK)
  ) u_pick (
    .clk_i    (CLK),
    .rst_i    (RST),
    .arb_en_i (state_q == StIdle),
    .i_req_i  (I_REQ),
    .d_req_i  (D_REQ),
    .grant_o  (grant),
    .owner_o  (pick_owner)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    err_d       = err_q;
    tmo_d       = tmo_q;

    unique case (state_q)
      StIdle: begin
        if (grant) begin
          owner_d   = pick_owner;
          mem_req_d = 1'b1;
          tmo_d     = '0;
          state_d   = StIssue;
          if (pick_owner == OwnD) begin
            mem_we_d    = D_WE;
            mem_addr_d  = D_ADDR;
            mem_wdata_d = D_WDATA;
            mem_be_d    = D_BE;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = I_ADDR;
            mem_wdata_d = '0;
            mem_be_d    = 4'hF;
          end
        end
      end
      // A completion while the strobe is still out cannot belong to this command.
      StIssue: state_d = StWait;
      StWait: begin
        if (MEM_RVALID) begin
          state_d = StResp;
          i_ack_d = (owner_q == OwnI);
          d_ack_d = (owner_q == OwnD);
          if (owner_q == OwnI) begin
            i_rdata_d = MEM_RDATA;
          end else begin
            d_rdata_d = mem_we_q ? '0 : MEM_RDATA;
          end
        end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
          // Abort: answer the owner with zero data and flag the error permanently.
          state_d = StResp;
          err_d   = 1'b1;
          i_ack_d = (owner_q == OwnI);
          d_ack_d = (owner_q == OwnD);
          if (owner_q == OwnI) begin
            i_rdata_d = '0;
          end else begin
            d_rdata_d = '0;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StResp: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      owner_q     <= OwnI;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      err_q       <= 1'b0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
    end
  end

  assign I_ACK     = i_ack_q;
  assign I_RDATA   = i_rdata_q;
  assign I_STALL   = I_REQ & ~i_ack_q;
  assign D_ACK     = d_ack_q;
  assign D_RDATA   = d_rdata_q;
  assign D_STALL   = D_REQ & ~d_ack_q;
  assign MEM_REQ   = mem_req_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = mem_wdata_q;
  assign MEM_BE    = mem_be_q;
  assign ERR       = err_q;

endmodule
